// File: rtl/ddr_port_arbiter_pkg.sv
// ddr_port_arbiter_pkg: shared FSM state encoding and transfer direction constants
package ddr_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, XFER = 2'd2, DONE = 2'd3} state_t;
  localparam logic LD = 1'b0;
  localparam logic ST = 1'b1;
endpackage

// File: rtl/ddr_port_arbiter_pick.sv
// ddr_arb_pick: store-first arbitration with load anti-starvation and same-tag RAW guard
module ddr_arb_pick
  import ddr_port_arbiter_pkg::*;
#(
  parameter int TAG_W      = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_req,
  input  logic             st_req,
  input  logic [TAG_W-1:0] ld_tag,
  input  logic [TAG_W-1:0] st_tag,
  input  logic             take,
  output logic             valid,
  output logic             dir
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  logic [SW-1:0] streak;
  logic          sat;
  always_comb begin
    sat   = streak == SW'(MAX_STREAK);
    valid = ld_req | st_req;
    dir   = !ld_req ? ST : !st_req ? LD : (sat && ld_tag != st_tag) ? LD : ST;
  end
  // Only store grants can starve the other side, so only the store streak is tracked.
  always_ff @(posedge clk or negedge reset)
    if (!reset) streak <= '0;
    else if (take && valid) streak <= (dir == ST && ld_req) ? (sat ? streak : streak + 1'b1) : '0;
endmodule

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares one DDR command/beat port between load and store requesters
module ddr_port_arbiter
  import ddr_port_arbiter_pkg::*;
#(
  parameter int NUM_TAGS   = 2,
  parameter int TAG_W      = $clog2(NUM_TAGS),
  parameter int LEN_W      = 8,
  parameter int MAX_STREAK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_req,
  input  logic [LEN_W-1:0] ld_len,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             ld_gnt,
  output logic             ld_done,
  input  logic             st_req,
  input  logic [LEN_W-1:0] st_len,
  input  logic [TAG_W-1:0] st_tag,
  output logic             st_gnt,
  output logic             st_done,
  output logic             mem_req,
  output logic             mem_is_wr,
  output logic [LEN_W-1:0] mem_len,
  output logic [TAG_W-1:0] mem_tag,
  input  logic             mem_ack,
  input  logic             mem_beat,
  output logic             busy
);
  state_t             state, state_d;
  logic               dir_q, dir_d, sel_valid, sel_dir, active_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [LEN_W:0]     cnt_q, cnt_d;
  ddr_arb_pick #(.TAG_W(TAG_W), .MAX_STREAK(MAX_STREAK)) u_pick (
    .clk    (clk),
    .reset  (reset),
    .ld_req (ld_req),
    .st_req (st_req),
    .ld_tag (ld_tag),
    .st_tag (st_tag),
    .take   (state == IDLE),
    .valid  (sel_valid),
    .dir    (sel_dir)
  );
  always_comb begin
    state_d = state;
    dir_d   = dir_q;
    len_d   = len_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    case (state)
      IDLE: if (sel_valid) begin
        state_d = CMD;
        dir_d   = sel_dir;
        len_d   = sel_dir == ST ? st_len : ld_len;
        tag_d   = sel_dir == ST ? st_tag : ld_tag;
        cnt_d   = '0;
      end
      CMD: state_d = mem_ack ? XFER : CMD;
      XFER: if (mem_beat) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == {1'b0, len_q} ? DONE : XFER;
      end
      default: state_d = IDLE;
    endcase
    active_d = state_d == CMD || state_d == XFER;
  end
  // Outputs are registered from next-state so they change exactly on state entry/exit.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      dir_q     <= LD;
      len_q     <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      ld_gnt    <= 1'b0;
      st_gnt    <= 1'b0;
      ld_done   <= 1'b0;
      st_done   <= 1'b0;
      mem_req   <= 1'b0;
      mem_is_wr <= 1'b0;
      mem_len   <= '0;
      mem_tag   <= '0;
    end else begin
      state     <= state_d;
      dir_q     <= dir_d;
      len_q     <= len_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      ld_gnt    <= active_d && dir_d == LD;
      st_gnt    <= active_d && dir_d == ST;
      ld_done   <= state_d == DONE && dir_d == LD;
      st_done   <= state_d == DONE && dir_d == ST;
      mem_req   <= state_d == CMD;
      mem_is_wr <= active_d && dir_d == ST;
      mem_len   <= active_d ? len_d : '0;
      mem_tag   <= active_d ? tag_d : '0;
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: directed self-checking bench for ddr_port_arbiter
module tb_ddr_port_arbiter;
  logic       clk = 1'b0, reset = 1'b0;
  logic       ld_req, st_req, ld_gnt, st_gnt, ld_done, st_done;
  logic [7:0] ld_len, st_len, mem_len;
  logic       ld_tag, st_tag, mem_tag;
  logic       mem_req, mem_is_wr, mem_ack, mem_beat, busy;
  logic [15:0] outs;
  int tests = 0, failed = 0;

  ddr_port_arbiter dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_len(ld_len), .ld_tag(ld_tag), .ld_gnt(ld_gnt), .ld_done(ld_done),
    .st_req(st_req), .st_len(st_len), .st_tag(st_tag), .st_gnt(st_gnt), .st_done(st_done),
    .mem_req(mem_req), .mem_is_wr(mem_is_wr), .mem_len(mem_len), .mem_tag(mem_tag),
    .mem_ack(mem_ack), .mem_beat(mem_beat), .busy(busy)
  );

  always #5 clk = ~clk;
  assign outs = {ld_gnt, ld_done, st_gnt, st_done, mem_req, mem_is_wr, mem_len, mem_tag, busy};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serves one burst as the memory side, checking grant fields, beat count and done pulse.
  task automatic burst(input string tag, input logic is_st, input int len, input int t,
                       input int ack_dly, input logic beat_cmd);
    int n = 0, bad = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_gnt"}, {ld_gnt, st_gnt, mem_is_wr}, is_st ? 3'b011 : 3'b100);
    chk({tag, "_len"}, mem_len, len);
    chk({tag, "_tag"}, mem_tag, t);
    mem_beat = beat_cmd;
    for (int d = 0; d < ack_dly; d++) begin @(negedge clk); if (!mem_req) bad++; end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack  = 1'b0;
    mem_beat = 1'b0;
    chk({tag, "_cmdhold"}, bad, 0);
    chk({tag, "_xfer"}, {mem_req, busy}, 2'b01);
    bad = 0;
    for (int i = 0; i <= len; i++) begin
      mem_beat = 1'b1;
      @(negedge clk);
      if (i < len && (ld_done || st_done || (is_st ? !st_gnt : !ld_gnt))) bad++;
    end
    mem_beat = 1'b0;
    chk({tag, "_early"}, bad, 0);
    chk({tag, "_done"}, {ld_done, st_done, ld_gnt, st_gnt, busy}, is_st ? 5'b01001 : 5'b10001);
  endtask

  initial begin
    {ld_req, st_req, mem_ack, mem_beat} = '0;
    ld_len = '0; st_len = '0; ld_tag = 1'b0; st_tag = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", outs, 0);
    ld_req = 1'b1; ld_len = 8'd3; ld_tag = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    chk("rst_hold", outs, 0);
    mem_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("first_arb", {ld_gnt, st_gnt}, 2'b10);
    burst("ld1", 1'b0, 3, 1, 2, 1'b0);
    ld_req = 1'b0;
    @(negedge clk);
    chk("ld1_idle", {busy, ld_done, st_gnt, mem_req}, 0);

    ld_len = 8'd1; ld_tag = 1'b0; st_len = 8'd2; st_tag = 1'b1;
    ld_req = 1'b1; st_req = 1'b1;
    burst("cont_st", 1'b1, 2, 1, 0, 1'b0);
    st_req = 1'b0;
    @(negedge clk);
    chk("cont_gap", {ld_gnt, mem_req, busy}, 0);
    @(negedge clk);
    chk("cont_ld_gnt", ld_gnt, 1);
    burst("cont_ld", 1'b0, 1, 0, 0, 1'b0);
    ld_req = 1'b0;
    @(negedge clk);

    st_len = 8'd0; st_tag = 1'b0; ld_len = 8'd0; ld_tag = 1'b1;
    st_req = 1'b1; ld_req = 1'b1;
    repeat (4) burst("starve_st", 1'b1, 0, 0, 0, 1'b0);
    burst("starve_ld", 1'b0, 0, 1, 0, 1'b0);
    burst("starve_st2", 1'b1, 0, 0, 0, 1'b0);
    repeat (3) burst("sat_st", 1'b1, 0, 0, 0, 1'b0);
    ld_tag = 1'b1; st_tag = 1'b1;
    burst("raw_st", 1'b1, 0, 1, 0, 1'b0);
    ld_tag = 1'b0;
    burst("sat_ld", 1'b0, 0, 0, 0, 1'b0);
    ld_req = 1'b0; st_req = 1'b0;
    @(negedge clk);

    st_len = 8'd0; st_tag = 1'b1; st_req = 1'b1;
    burst("len0", 1'b1, 0, 1, 0, 1'b1);
    st_req = 1'b0;
    ld_len = 8'd255; ld_tag = 1'b1; ld_req = 1'b1;
    burst("len255", 1'b0, 255, 1, 1, 1'b1);
    ld_req = 1'b0;
    @(negedge clk);

    ld_len = 8'd7; ld_tag = 1'b0; ld_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_cmd", {ld_gnt, mem_req}, 2'b11);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; mem_beat = 1'b1;
    repeat (2) @(negedge clk);
    mem_beat = 1'b0;
    chk("mid_busy", {ld_gnt, busy, ld_done}, 3'b110);
    reset = 1'b0;
    #1;
    chk("mid_rst_outs", outs, 0);
    ld_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_nodone", outs, 0);
    reset = 1'b1; st_len = 8'd1; st_tag = 1'b1; st_req = 1'b1;
    @(negedge clk);
    chk("post_rst_arb", {st_gnt, mem_req}, 2'b11);
    burst("post_rst", 1'b1, 1, 1, 0, 1'b0);
    st_req = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", outs, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/ddr_port_arbiter.md
DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 2, number of double-buffer tags.
REQ-002 SHALL have parameter TAG_W, default $clog2(NUM_TAGS), tag width.
REQ-003 SHALL have parameter LEN_W, default 8, burst-length field width (length encoded as beats-1).
REQ-004 SHALL have parameter MAX_STREAK, default 4, consecutive same-side grants allowed while the other side waits.
REQ-005 SHALL have port clk, input, 1, single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have ports ld_req (in, 1), ld_len (in, LEN_W), ld_tag (in, TAG_W), ld_gnt (out, 1) and ld_done (out, 1) for the load-memory requester.
REQ-008 SHALL have ports st_req (in, 1), st_len (in, LEN_W), st_tag (in, TAG_W), st_gnt (out, 1) and st_done (out, 1) for the store-memory requester.
REQ-009 SHALL have ports mem_req (out, 1), mem_is_wr (out, 1), mem_len (out, LEN_W), mem_tag (out, TAG_W), mem_ack (in, 1) and mem_beat (in, 1) for the shared DDR command/beat port.
REQ-010 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, CMD, XFER and DONE.
REQ-012 IDLE: when no request is pending, SHALL remain in IDLE.
REQ-013 IDLE: when exactly one request is pending, SHALL select that requester.
REQ-014 IDLE: when both requests are pending, SHALL select the store side by default, since a store frees a buffer.
REQ-015 IDLE arbitration exception: SHALL select the load side when the store streak equals MAX_STREAK, unless ld_tag equals st_tag.
REQ-016 On ld_tag equal to st_tag with both requests pending, SHALL always select the store side first (RAW guard).
REQ-017 On selection, SHALL latch len, tag and direction into a register and move to CMD on the next edge.
REQ-018 The selected gnt, mem_req, mem_is_wr (1 = store), mem_len and mem_tag SHALL be registered and SHALL hold from CMD entry through XFER exit.
REQ-019 CMD: SHALL hold mem_req high until mem_ack, then drop mem_req and move to XFER.
REQ-020 CMD: mem_beat SHALL be ignored.
REQ-021 XFER: SHALL keep a beat counter of width LEN_W+1 that increments on each mem_beat.
REQ-022 XFER: a mem_beat arriving with count equal to the latched len SHALL move the FSM to DONE, so exactly len+1 beats are transferred.
REQ-023 DONE: SHALL last one cycle, pulse the owner's done, deassert gnt and return to IDLE.
REQ-024 Requests sampled in the DONE cycle SHALL be ignored, giving a minimum 1-cycle gap between bursts.
REQ-025 Requesters SHALL hold req, len and tag stable from assertion until their done pulse; the arbiter samples them only in IDLE.
REQ-026 Streak counter SHALL increment, saturating at MAX_STREAK, when a side is granted while the other side's req is high.
REQ-027 Streak counter SHALL clear when the other side is granted, or when the other side's req is low at grant time.
REQ-028 ld_gnt and st_gnt SHALL be mutually exclusive; at most one done SHALL pulse per cycle.
REQ-029 len = 0 SHALL produce a 1-beat burst; len = 2^LEN_W-1 SHALL produce a 2^LEN_W-beat burst with no counter overflow.
REQ-030 mem_ack and mem_beat arriving in the same CMD cycle SHALL count as ack only.

Reset
REQ-031 On reset low, SHALL asynchronously force state IDLE and clear the beat counter, streak counter and latched fields.
REQ-032 On reset low, all outputs SHALL be 0 (gnts, dones, mem_req, mem_is_wr, mem_len, mem_tag, busy).
REQ-033 Reset asserted mid-burst SHALL abandon the burst with no done pulse; the first arbitration SHALL occur on the first edge after reset deassertion.

Structure
REQ-034 State encoding (IDLE=0, CMD=1, XFER=2, DONE=3) and the direction constants (LD=0, ST=1) SHALL live in the shared accelerator package.
REQ-035 Arbitration (priority, streak and RAW guard) SHALL be a sub-module, ddr_arb_pick, that is purely combinational apart from the streak register; the FSM and counters SHALL remain in ddr_port_arbiter.

Verification
REQ-036 Single load: ld_req=1, ld_len=3, ld_tag=1, mem_ack on cycle 3, 4 beats -> mem_is_wr=0, mem_tag=1, one ld_done pulse after the 4th beat, st_gnt never asserted.
REQ-037 Contention: ld_req and st_req both high, tags 0 and 1 -> store granted first; load granted after st_done and a 1-cycle gap.
REQ-038 Starvation: st_req held high for 5 back-to-back 1-beat bursts with ld_req high, tags differ -> 4 store grants, then 1 load grant, then store again.
REQ-039 RAW guard: ld_tag = st_tag = 1, streak at MAX_STREAK -> store still granted first.
REQ-040 Boundaries: len=0 -> exactly 1 beat; len=255 -> exactly 256 beats then done; mem_beat during CMD -> not counted.
REQ-041 Reset low in XFER after 2 of 8 beats -> all outputs 0 immediately, no done pulse; a fresh request after release is served normally.
